// File: rtl/ro_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: ids, register payloads,
// instruction kinds and the per-entry payload record.
package ro_buffer_pkg;

    localparam int unsigned RO_BUFFER_ID_WIDTH = 4;
    localparam int unsigned REG_ID_WIDTH       = 5;
    localparam int unsigned REG_WIDTH          = 32;
    localparam int unsigned PC_WIDTH           = 32;
    localparam int unsigned STAT_WIDTH         = 32;
    localparam int unsigned RO_BUFFER_SIZE     = (1 << RO_BUFFER_ID_WIDTH) - 1;

    typedef logic [REG_WIDTH-1:0]          reg_t;
    typedef logic [REG_ID_WIDTH-1:0]       reg_id_t;
    typedef logic [RO_BUFFER_ID_WIDTH-1:0] rob_id_t;
    typedef logic [RO_BUFFER_ID_WIDTH-1:0] count_t;
    typedef logic [PC_WIDTH-1:0]           pc_t;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2
    } kind_e;

    typedef struct packed {
        logic    mispredict;
        kind_e   kind;
        reg_id_t rd;
        reg_t    value;
        pc_t     target;
    } rob_entry_t;

    // Id 0 means "no tag", so the ring runs 1..RO_BUFFER_SIZE.
    function automatic rob_id_t next_id(input rob_id_t id);
        return (id == rob_id_t'(RO_BUFFER_SIZE)) ? rob_id_t'(1) : id + rob_id_t'(1);
    endfunction

endpackage

// File: rtl/ro_buffer_if.sv
// Reorder-buffer bus bundle: issuer allocation/query, CDB results, commit
// to reg_file/LSB and the flush redirect towards fetch.
interface ro_buffer_if;
    import ro_buffer_pkg::*;

    logic    issue_valid_from_issuer;
    reg_id_t rd_from_issuer;
    kind_e   kind_from_issuer;
    rob_id_t dest_to_issuer;
    logic    full_to_issuer;

    rob_id_t qj_from_issuer;
    logic    qj_ready_to_issuer;
    reg_t    qj_value_to_issuer;
    rob_id_t qk_from_issuer;
    logic    qk_ready_to_issuer;
    reg_t    qk_value_to_issuer;

    rob_id_t cdb_id;
    reg_t    cdb_value;
    logic    cdb_mispredict;
    pc_t     cdb_target;

    rob_id_t dest_to_reg_file;
    reg_id_t rd_to_reg_file;
    reg_t    value_to_reg_file;
    logic    store_commit_to_lsb;
    logic    reset_to_rob_bus;
    pc_t     pc_to_fetcher;

    modport slave (
        input  issue_valid_from_issuer, rd_from_issuer, kind_from_issuer,
        input  qj_from_issuer, qk_from_issuer,
        input  cdb_id, cdb_value, cdb_mispredict, cdb_target,
        output dest_to_issuer, full_to_issuer,
        output qj_ready_to_issuer, qj_value_to_issuer,
        output qk_ready_to_issuer, qk_value_to_issuer,
        output dest_to_reg_file, rd_to_reg_file, value_to_reg_file,
        output store_commit_to_lsb, reset_to_rob_bus, pc_to_fetcher
    );

    modport master (
        output issue_valid_from_issuer, rd_from_issuer, kind_from_issuer,
        output qj_from_issuer, qk_from_issuer,
        output cdb_id, cdb_value, cdb_mispredict, cdb_target,
        input  dest_to_issuer, full_to_issuer,
        input  qj_ready_to_issuer, qj_value_to_issuer,
        input  qk_ready_to_issuer, qk_value_to_issuer,
        input  dest_to_reg_file, rd_to_reg_file, value_to_reg_file,
        input  store_commit_to_lsb, reset_to_rob_bus, pc_to_fetcher
    );

endinterface

// File: rtl/ro_buffer_ptr.sv
// Ring pointer over ids 1..RO_BUFFER_SIZE; clears back to id 1 and skips id 0
// when it wraps.
module ro_buffer_ptr
    import ro_buffer_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    clr,
    output rob_id_t ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= rob_id_t'(1);
        end else if (clr) begin
            ptr <= rob_id_t'(1);
        end else if (en) begin
            ptr <= next_id(ptr);
        end
    end

endmodule

// File: rtl/ro_buffer.sv
// Reorder buffer: hands out ROB ids, captures CDB results and retires one
// entry per cycle in program order. Define ROB_STAT_EN for commit/flush counters.
module ro_buffer
    import ro_buffer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    ro_buffer_if.slave bus
`ifdef ROB_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0] commit_count_out,
    output logic [STAT_WIDTH-1:0] mispredict_count_out
`endif
);

    localparam int unsigned DEPTH = RO_BUFFER_SIZE + 1;

    rob_entry_t       entries [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    count_t           count;
    rob_id_t          head;
    rob_id_t          tail;

    rob_id_t dest_q;
    reg_id_t rd_q;
    reg_t    value_q;
    logic    store_q;
    logic    flush_q;
    pc_t     pc_q;

    logic       full_c;
    logic       alloc_c;
    logic       commit_c;
    logic       flush_c;
    logic       cdb_we_c;
    logic       qj_hit_c;
    logic       qk_hit_c;
    rob_entry_t head_entry_c;

    assign head_entry_c = entries[head];

    // Full uses the pre-commit count; the flush cycle also refuses issue.
    assign full_c   = (count == count_t'(RO_BUFFER_SIZE)) || flush_q;
    assign alloc_c  = rdy && bus.issue_valid_from_issuer && !full_c;
    assign commit_c = rdy && !flush_q && (count != '0) && ready[head];
    assign flush_c  = commit_c && head_entry_c.mispredict && (head_entry_c.kind == KIND_BRANCH);
    assign cdb_we_c = rdy && !flush_q && (bus.cdb_id != '0) && busy[bus.cdb_id];

    ro_buffer_ptr u_head_ptr (
        .clk (clk),
        .rst (rst),
        .en  (commit_c),
        .clr (flush_c),
        .ptr (head)
    );

    ro_buffer_ptr u_tail_ptr (
        .clk (clk),
        .rst (rst),
        .en  (alloc_c),
        .clr (flush_c),
        .ptr (tail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush_c) begin
            count <= '0;
        end else if (alloc_c && !commit_c) begin
            count <= count + count_t'(1);
        end else if (commit_c && !alloc_c) begin
            count <= count - count_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= '0;
            ready <= '0;
        end else if (flush_c) begin
            busy  <= '0;
            ready <= '0;
        end else begin
            if (alloc_c) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
            end
            if (cdb_we_c) begin
                ready[bus.cdb_id] <= 1'b1;
            end
            if (commit_c) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
            end
        end
    end

    // Payload is only trusted while the matching ready bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries <= '{default: '0};
        end else begin
            if (alloc_c) begin
                entries[tail] <= '{mispredict: 1'b0,
                                   kind:       bus.kind_from_issuer,
                                   rd:         bus.rd_from_issuer,
                                   value:      '0,
                                   target:     '0};
            end
            if (cdb_we_c) begin
                entries[bus.cdb_id].value      <= bus.cdb_value;
                entries[bus.cdb_id].mispredict <= bus.cdb_mispredict;
                entries[bus.cdb_id].target     <= bus.cdb_target;
            end
        end
    end

    // Commit stage; stores retire with rd 0 so reg_file leaves registers alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q  <= '0;
            rd_q    <= '0;
            value_q <= '0;
            store_q <= 1'b0;
            flush_q <= 1'b0;
            pc_q    <= '0;
        end else if (rdy) begin
            dest_q  <= commit_c ? head : '0;
            rd_q    <= (commit_c && (head_entry_c.kind != KIND_STORE)) ? head_entry_c.rd : '0;
            value_q <= commit_c ? head_entry_c.value : '0;
            store_q <= commit_c && (head_entry_c.kind == KIND_STORE);
            flush_q <= flush_c;
            pc_q    <= flush_c ? head_entry_c.target : '0;
        end
    end

    assign bus.dest_to_issuer      = full_c ? '0 : tail;
    assign bus.full_to_issuer      = full_c;
    assign bus.dest_to_reg_file    = dest_q;
    assign bus.rd_to_reg_file      = rd_q;
    assign bus.value_to_reg_file   = value_q;
    assign bus.store_commit_to_lsb = store_q;
    assign bus.reset_to_rob_bus    = flush_q;
    assign bus.pc_to_fetcher       = pc_q;

    // Operand queries forward a same-cycle CDB result ahead of stored values.
    assign qj_hit_c = (bus.qj_from_issuer != '0) && (bus.cdb_id == bus.qj_from_issuer);
    assign qk_hit_c = (bus.qk_from_issuer != '0) && (bus.cdb_id == bus.qk_from_issuer);

    assign bus.qj_ready_to_issuer = (bus.qj_from_issuer != '0) && (ready[bus.qj_from_issuer] || qj_hit_c);
    assign bus.qk_ready_to_issuer = (bus.qk_from_issuer != '0) && (ready[bus.qk_from_issuer] || qk_hit_c);

    assign bus.qj_value_to_issuer = qj_hit_c ? bus.cdb_value :
                                    ((bus.qj_from_issuer != '0) && ready[bus.qj_from_issuer]) ?
                                    entries[bus.qj_from_issuer].value : '0;
    assign bus.qk_value_to_issuer = qk_hit_c ? bus.cdb_value :
                                    ((bus.qk_from_issuer != '0) && ready[bus.qk_from_issuer]) ?
                                    entries[bus.qk_from_issuer].value : '0;

`ifdef ROB_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_count_out     <= '0;
            mispredict_count_out <= '0;
        end else begin
            if (commit_c) begin
                commit_count_out <= commit_count_out + STAT_WIDTH'(1);
            end
            if (flush_c) begin
                mispredict_count_out <= mispredict_count_out + STAT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ro_buffer.sv
// Directed bench for ro_buffer: allocation order, out-of-order completion,
// CDB forwarding, mispredict flush, store commit, rdy hold, async reset, full wrap.
module tb_ro_buffer;
    import ro_buffer_pkg::*;

    logic clk;
    logic rst;
    logic rdy;
    int   checks;
    int   errors;

    ro_buffer_if bus ();

`ifdef ROB_STAT_EN
    logic [STAT_WIDTH-1:0] commit_count_out;
    logic [STAT_WIDTH-1:0] mispredict_count_out;
`endif

    ro_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .bus                  (bus)
`ifdef ROB_STAT_EN
        ,
        .commit_count_out     (commit_count_out),
        .mispredict_count_out (mispredict_count_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.issue_valid_from_issuer = 1'b0;
        bus.rd_from_issuer          = '0;
        bus.kind_from_issuer        = KIND_ALU;
        bus.qj_from_issuer          = '0;
        bus.qk_from_issuer          = '0;
        bus.cdb_id                  = '0;
        bus.cdb_value               = '0;
        bus.cdb_mispredict          = 1'b0;
        bus.cdb_target              = '0;
    endtask

    task automatic drive_issue(input reg_id_t rd, input kind_e kind);
        bus.issue_valid_from_issuer = 1'b1;
        bus.rd_from_issuer          = rd;
        bus.kind_from_issuer        = kind;
    endtask

    task automatic drive_cdb(input rob_id_t id, input reg_t value, input logic mp, input pc_t target);
        bus.cdb_id         = id;
        bus.cdb_value      = value;
        bus.cdb_mispredict = mp;
        bus.cdb_target     = target;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rdy    = 1'b1;
        drive_idle();
        #12;
        check("rst_dest_rf",  32'(bus.dest_to_reg_file), 32'd0);
        check("rst_flush",    32'(bus.reset_to_rob_bus), 32'd0);
        check("rst_full",     32'(bus.full_to_issuer), 32'd0);
        check("rst_dest_iss", 32'(bus.dest_to_issuer), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Mispredicted branch id 2 behind ALU id 1
        drive_issue(5'd1, KIND_ALU);
        #1 check("br_alloc_alu", 32'(bus.dest_to_issuer), 32'd1);
        tick();
        drive_issue(5'd0, KIND_BRANCH);
        #1 check("br_alloc_br", 32'(bus.dest_to_issuer), 32'd2);
        tick();
        drive_idle();
        drive_cdb(4'd1, 32'h0000_00A1, 1'b0, 32'h0);
        tick();
        drive_cdb(4'd2, 32'h0, 1'b1, 32'h0000_0100);
        tick();
        drive_idle();
        check("br_c1_dest",  32'(bus.dest_to_reg_file), 32'd1);
        check("br_c1_rd",    32'(bus.rd_to_reg_file), 32'd1);
        check("br_c1_value", bus.value_to_reg_file, 32'h0000_00A1);
        check("br_c1_flush", 32'(bus.reset_to_rob_bus), 32'd0);
        tick();
        check("br_c2_dest",  32'(bus.dest_to_reg_file), 32'd2);
        check("br_c2_rd",    32'(bus.rd_to_reg_file), 32'd0);
        check("br_c2_flush", 32'(bus.reset_to_rob_bus), 32'd1);
        check("br_c2_pc",    bus.pc_to_fetcher, 32'h0000_0100);
        drive_issue(5'd9, KIND_ALU);
        #1 check("flush_full", 32'(bus.full_to_issuer), 32'd1);
        check("flush_dest_iss", 32'(bus.dest_to_issuer), 32'd0);
        tick();
        drive_idle();
        check("post_flush_pulse", 32'(bus.reset_to_rob_bus), 32'd0);
        check("post_flush_pc",    bus.pc_to_fetcher, 32'd0);
        check("post_flush_dest",  32'(bus.dest_to_reg_file), 32'd0);
        check("post_flush_full",  32'(bus.full_to_issuer), 32'd0);

        // Three ALU ops, results out of order
        for (int i = 1; i <= 3; i++) begin
            drive_issue(reg_id_t'(i), KIND_ALU);
            #1 check("alu_alloc", 32'(bus.dest_to_issuer), 32'(i));
            tick();
        end
        drive_idle();
        drive_cdb(4'd2, 32'h0000_0022, 1'b0, 32'h0);
        tick();
        drive_cdb(4'd1, 32'h0000_0011, 1'b0, 32'h0);
        tick();
        drive_idle();
        tick();
        check("ooo_c1_dest",  32'(bus.dest_to_reg_file), 32'd1);
        check("ooo_c1_rd",    32'(bus.rd_to_reg_file), 32'd1);
        check("ooo_c1_value", bus.value_to_reg_file, 32'h0000_0011);
        bus.qj_from_issuer = 4'd3;
        #1 check("ooo_q3_pending", 32'(bus.qj_ready_to_issuer), 32'd0);
        tick();
        check("ooo_c2_dest",  32'(bus.dest_to_reg_file), 32'd2);
        check("ooo_c2_rd",    32'(bus.rd_to_reg_file), 32'd2);
        check("ooo_c2_value", bus.value_to_reg_file, 32'h0000_0022);
        drive_idle();
        tick();
        check("ooo_id3_wait", 32'(bus.dest_to_reg_file), 32'd0);
        drive_cdb(4'd3, 32'h0000_0033, 1'b0, 32'h0);
        tick();
        drive_idle();
        tick();
        check("ooo_c3_dest", 32'(bus.dest_to_reg_file), 32'd3);

        // Same-cycle CDB forwarding on id 4
        drive_issue(5'd4, KIND_ALU);
        #1 check("fwd_alloc", 32'(bus.dest_to_issuer), 32'd4);
        tick();
        drive_idle();
        drive_cdb(4'd4, 32'h0000_DEAD, 1'b0, 32'h0);
        bus.qj_from_issuer = 4'd4;
        #1 check("fwd_qj_ready", 32'(bus.qj_ready_to_issuer), 32'd1);
        check("fwd_qj_value", bus.qj_value_to_issuer, 32'h0000_DEAD);
        check("fwd_qk0_ready", 32'(bus.qk_ready_to_issuer), 32'd0);
        check("fwd_qk0_value", bus.qk_value_to_issuer, 32'd0);
        tick();
        drive_idle();
        bus.qk_from_issuer = 4'd4;
        #1 check("stored_qk_ready", 32'(bus.qk_ready_to_issuer), 32'd1);
        check("stored_qk_value", bus.qk_value_to_issuer, 32'h0000_DEAD);
        tick();
        check("fwd_c_dest",  32'(bus.dest_to_reg_file), 32'd4);
        check("fwd_c_value", bus.value_to_reg_file, 32'h0000_DEAD);
        drive_idle();

        // Store commit
        drive_issue(5'd7, KIND_STORE);
        #1 check("st_alloc", 32'(bus.dest_to_issuer), 32'd5);
        tick();
        drive_idle();
        drive_cdb(4'd5, 32'h0000_0055, 1'b0, 32'h0);
        tick();
        drive_idle();
        tick();
        check("st_pulse", 32'(bus.store_commit_to_lsb), 32'd1);
        check("st_rd",    32'(bus.rd_to_reg_file), 32'd0);
        check("st_dest",  32'(bus.dest_to_reg_file), 32'd5);
        tick();
        check("st_pulse_end", 32'(bus.store_commit_to_lsb), 32'd0);

        // rdy hold, then async reset with ids 7..11 busy
        for (int i = 6; i <= 11; i++) begin
            drive_issue(reg_id_t'(i), KIND_ALU);
            tick();
        end
        drive_idle();
        drive_cdb(4'd6, 32'h0000_0066, 1'b0, 32'h0);
        tick();
        rdy = 1'b0;
        drive_cdb(4'd7, 32'h0000_0077, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rdy_hold_dest", 32'(bus.dest_to_reg_file), 32'd0);
        end
        rdy = 1'b1;
        drive_idle();
        bus.qj_from_issuer = 4'd7;
        #1 check("rdy_no_cdb", 32'(bus.qj_ready_to_issuer), 32'd0);
        tick();
        check("rdy_resume_dest",  32'(bus.dest_to_reg_file), 32'd6);
        check("rdy_resume_value", bus.value_to_reg_file, 32'h0000_0066);
        #2 rst = 1'b1;
        #1 check("arst_dest",     32'(bus.dest_to_reg_file), 32'd0);
        check("arst_value",    bus.value_to_reg_file, 32'd0);
        check("arst_rd",       32'(bus.rd_to_reg_file), 32'd0);
        check("arst_dest_iss", 32'(bus.dest_to_issuer), 32'd1);
        check("arst_full",     32'(bus.full_to_issuer), 32'd0);
        check("arst_q7",       32'(bus.qj_ready_to_issuer), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        drive_idle();

        // Fill all 15 ids, then refuse issue on the commit cycle
        for (int i = 1; i <= 15; i++) begin
            drive_issue(reg_id_t'(i), KIND_ALU);
            #1 check("fill_id", 32'(bus.dest_to_issuer), 32'(i));
            tick();
        end
        drive_issue(5'd16, KIND_ALU);
        #1 check("full_flag",     32'(bus.full_to_issuer), 32'd1);
        check("full_dest_iss", 32'(bus.dest_to_issuer), 32'd0);
        drive_cdb(4'd1, 32'h0000_0001, 1'b0, 32'h0);
        tick();
        drive_cdb(4'd0, 32'h0, 1'b0, 32'h0);
        #1 check("commit_cycle_full", 32'(bus.full_to_issuer), 32'd1);
        check("commit_cycle_dest", 32'(bus.dest_to_issuer), 32'd0);
        tick();
        check("wrap_commit_dest", 32'(bus.dest_to_reg_file), 32'd1);
        check("wrap_full_clear",  32'(bus.full_to_issuer), 32'd0);
        check("wrap_dest_iss",    32'(bus.dest_to_issuer), 32'd1);
        tick();
        check("refill_full",     32'(bus.full_to_issuer), 32'd1);
        check("refill_dest_iss", 32'(bus.dest_to_issuer), 32'd0);
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
